// File: rtl/teachee_stream_pkg.sv
// Shared types and constants for the COBS stream arbiter.
package teachee_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        FLUSH  = 2'd3
    } arb_state_t;

    localparam logic [7:0] COBS_DELIM = 8'h00;

endpackage

// File: rtl/packet_timeout_counter.sv
// Idle-cycle counter for the granted source; flags expiry on the LIMIT-th idle cycle.
module packet_timeout_counter #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear wins over increment
    always_comb begin
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign expired = inc && (cnt_q == W'(LIMIT - 1));

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cobs_stream_arbiter.sv
// Packet-level 2:1 round-robin merge of COBS byte streams onto one AXIS link.
// Optional forced-flush on a stalled source is enabled by defining ARB_TIMEOUT_EN.
module cobs_stream_arbiter
    import teachee_stream_pkg::*;
#(
    parameter logic [7:0] DELIM          = COBS_DELIM,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] src_en,
    input  logic [7:0] s0_tdata,
    input  logic       s0_tvalid,
    output logic       s0_tready,
    input  logic [7:0] s1_tdata,
    input  logic       s1_tvalid,
    output logic       s1_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic [1:0] grant,
    output logic       timeout_evt
);

    arb_state_t state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_q, last_d;
    logic       timeout_evt_q, timeout_evt_d;
    logic [1:0] cand_s;
    logic       eop0_s, eop1_s;

    assign cand_s = src_en & {s1_tvalid, s0_tvalid};
    assign eop0_s = s0_tvalid && m_tready && (s0_tdata == DELIM);
    assign eop1_s = s1_tvalid && m_tready && (s1_tdata == DELIM);

`ifdef ARB_TIMEOUT_EN
    logic expired_s, cnt_clear_s, cnt_inc_s, accept_s;

    assign accept_s    = ((state_q == GRANT0) && s0_tvalid && m_tready) ||
                         ((state_q == GRANT1) && s1_tvalid && m_tready);
    assign cnt_clear_s = (state_q == IDLE) || (state_q == FLUSH) || accept_s;
    assign cnt_inc_s   = ((state_q == GRANT0) && !s0_tvalid) ||
                         ((state_q == GRANT1) && !s1_tvalid);

    packet_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear_s),
        .inc     (cnt_inc_s),
        .expired (expired_s)
    );
`else
    localparam int unused_timeout_cycles_lp = TIMEOUT_CYCLES;
`endif

    // arbitration FSM next state; last_q records the most recent owner for the tie-break
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        timeout_evt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_s[0] && (!cand_s[1] || last_q)) begin
                    state_d = GRANT0;
                    grant_d = 2'b01;
                end else if (cand_s[1]) begin
                    state_d = GRANT1;
                    grant_d = 2'b10;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT0: begin
                if (eop0_s) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (expired_s) begin
                    state_d = FLUSH;
`endif
                end else begin
                    state_d = GRANT0;
                end
            end
            GRANT1: begin
                if (eop1_s) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                end else if (expired_s) begin
                    state_d = FLUSH;
`endif
                end else begin
                    state_d = GRANT1;
                end
            end
`ifdef ARB_TIMEOUT_EN
            FLUSH: begin
                if (m_tready) begin
                    state_d       = IDLE;
                    grant_d       = 2'b00;
                    last_d        = grant_q[1];
                    timeout_evt_d = 1'b1;
                end else begin
                    state_d = FLUSH;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // FSM and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= 2'b00;
            last_q        <= 1'b1;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    // zero-latency datapath mux; the losing source always sees tready low
    always_comb begin
        m_tdata   = 8'h00;
        m_tvalid  = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state_q)
            GRANT0: begin
                m_tdata   = s0_tdata;
                m_tvalid  = s0_tvalid;
                s0_tready = m_tready;
            end
            GRANT1: begin
                m_tdata   = s1_tdata;
                m_tvalid  = s1_tvalid;
                s1_tready = m_tready;
            end
`ifdef ARB_TIMEOUT_EN
            FLUSH: begin
                m_tdata  = DELIM;
                m_tvalid = 1'b1;
            end
`endif
            default: begin
                m_tdata = 8'h00;
            end
        endcase
    end

    assign grant       = grant_q;
    assign timeout_evt = timeout_evt_q;

endmodule
